closest_hit_tracker: RTL and testbench
======================================

// Module: closest_hit_tracker
// PURPOSE
//  Downstream of the pipelined ray/triangle intersection stage. Consumes one
//  (t, hit) result per cycle for a stream of triangles tested against one ray.
//  Keeps the nearest hit (minimum t) and its triangle id. At each ray's last
//  triangle, pushes {hit, t, tri_id, ray_id} into an output FIFO for the shader.
// PARAMETERS
//  TRI_ID_W   16  width of triangle index carried alongside each result
//  RAY_ID_W   16  width of ray sequence counter (wraps)
//  FIFO_DEPTH 4   output result FIFO entries (power of 2, >=2)
//  T_MISS     32'sh7FFFFFFF  o_t value reported for a ray with no hit
// PORTS
//  i_clk      in   1         clock
//  i_rstn     in   1         async active-low reset
//  i_valid    in   1         input sample valid (intersection o_valid)
//  i_t        in   32        signed Q16.16 hit distance (intersection o_t)
//  i_hit      in   1         triangle hit (intersection o_result)
//  i_tri_id   in   TRI_ID_W  triangle index, delay-matched to i_t
//  i_last     in   1         sample is last triangle of current ray
//  i_ready    in   1         consumer ready for o_* result
//  o_valid    out  1         result available (FIFO not empty)
//  o_hit      out  1         ray hit any triangle
//  o_t        out  32        signed nearest t, T_MISS if no hit
//  o_tri_id   out  TRI_ID_W  nearest triangle index, 0 if no hit
//  o_ray_id   out  RAY_ID_W  sequence number of completed ray
//  o_overflow out  1         sticky: result dropped because FIFO full
// BEHAVIOUR
//  - Reset (async, i_rstn=0): accumulator EMPTY, best_t=T_MISS, best_id=0,
//    ray counter 0, FIFO empty; o_valid=0, o_hit=0, o_t=T_MISS, o_tri_id=0,
//    o_ray_id=0, o_overflow=0. Reset mid-ray discards partial state.
//  - No backpressure on input: every i_valid sample is consumed same cycle.
//  - Accumulator FSM: EMPTY (no hit yet for this ray), HOLD (best valid).
//    EMPTY -> HOLD on i_valid & i_hit & !i_last. HOLD -> EMPTY on i_valid & i_last.
//    EMPTY stays EMPTY on miss or on i_last (ray complete).
//  - Update rule on i_valid & i_hit: take sample if state EMPTY or i_t < best_t
//    (signed compare, strictly less). Equal t keeps earlier triangle.
//  - i_valid & !i_hit: accumulator unchanged.
//  - On i_valid & i_last: final = current sample merged with accumulator by the
//    same rule (combinational); final pushed into FIFO with ray_id = counter;
//    counter += 1 (mod 2^RAY_ID_W); accumulator cleared to EMPTY same edge so a
//    new ray may start the very next cycle. Single-triangle ray (i_last on first
//    sample) is legal.
//  - Latency: o_valid rises 1 cycle after the i_last sample edge (FIFO empty case).
//  - Output: o_* show FIFO head, registered; pop on o_valid & i_ready.
//  - FIFO full & push & no pop: result dropped, o_overflow set (sticky until
//    reset), ray counter still increments. Full & push & pop same cycle: both
//    occur, no overflow. Empty & pop request: ignored.
//  - i_last with i_valid=0 is ignored. Inputs ignored when i_valid=0.
//  - Miss result: o_hit=0, o_t=T_MISS, o_tri_id=0.
// TESTING
//  1 Reset: assert i_rstn=0 mid-ray -> all outputs at reset values, next ray
//    id 0, no stale best from prior samples.
//  2 Ray of 3 samples t=0x30000 id5 hit, t=0x18000 id9 hit, t=0x10000 id2 miss
//    (last) -> one cycle later o_valid=1, o_hit=1, o_t=0x18000, o_tri_id=9, ray 0.
//  3 Tie: t=0x20000 id3 hit, t=0x20000 id4 hit last -> o_tri_id=3.
//  4 All-miss ray of 2 samples -> o_hit=0, o_t=0x7FFFFFFF, o_tri_id=0; then
//    back-to-back single-sample rays (i_last every cycle) -> ray ids 1,2,3 in order.
//  5 i_ready=0, push 5 rays into depth-4 FIFO -> 4 held, o_overflow=1, fifth
//    dropped; raise i_ready -> ids 0..3 drained, o_overflow stays 1.
//  6 FIFO full, push and pop same cycle -> no overflow, count stays 4; ray id
//    counter wraps 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/closest_hit_tracker.sv
// Tracks the nearest hit over each ray's triangle stream and queues one result per ray.
// Latency: result visible on o_valid 1 cycle after the ray's i_last sample (FIFO empty).
// Backpressure: none on input; i_ready pops the result FIFO, results arriving when full are dropped (o_overflow).
//
// Ports:
//   i_clk, i_rstn           clock, async active-low reset
//   i_valid/i_t/i_hit       one intersection result per cycle (signed Q16.16 t)
//   i_tri_id/i_last         triangle index, last-triangle-of-ray marker
//   i_ready                 consumer accepts the head result
//   o_valid/o_hit/o_t       head result: valid, hit flag, nearest t (T_MISS on miss)
//   o_tri_id/o_ray_id       nearest triangle (0 on miss), ray sequence number
//   o_overflow              sticky: a result was dropped because the FIFO was full

// Small generic FIFO, pointer-based with a wrap bit to tell full from empty.
// Latency: written entry readable the cycle after the write.
// Backpressure: a write while full is accepted only if a read happens the same cycle.
module chit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         full,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         rd_pop;
  logic         wr_en;

  assign rd_vld = (wr_ptr != rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_pop = rd_vld && rd_rdy;
  // A pop frees the head slot this edge, so a simultaneous write into a full FIFO fits.
  assign wr_en  = wr_vld && (!full || rd_pop);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

module closest_hit_tracker #(
  parameter int                 TRI_ID_W   = 16,
  parameter int                 RAY_ID_W   = 16,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic signed [31:0] T_MISS     = 32'sh7FFFFFFF
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_valid,
  input  logic signed [31:0]         i_t,
  input  logic                       i_hit,
  input  logic        [TRI_ID_W-1:0] i_tri_id,
  input  logic                       i_last,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic                       o_hit,
  output logic signed [31:0]         o_t,
  output logic        [TRI_ID_W-1:0] o_tri_id,
  output logic        [RAY_ID_W-1:0] o_ray_id,
  output logic                       o_overflow
);
  typedef struct packed {
    logic                hit;
    logic [31:0]         t;
    logic [TRI_ID_W-1:0] tri_id;
    logic [RAY_ID_W-1:0] ray_id;
  } res_t;

  typedef enum logic {ST_EMPTY, ST_HOLD} acc_state_t;

  acc_state_t                state_q, state_d;
  logic signed [31:0]        best_t_q, best_t_d;
  logic [TRI_ID_W-1:0]       best_id_q, best_id_d;
  logic [RAY_ID_W-1:0]       ray_cnt_q;
  logic                      overflow_q;

  logic take;
  logic push;
  logic pop;
  logic fifo_full;
  logic fifo_vld;
  res_t push_dat;
  res_t head;

  // Strictly-less compare: on equal t the earlier triangle stays.
  assign take = i_valid && i_hit && ((state_q == ST_EMPTY) || (i_t < best_t_q));
  assign push = i_valid && i_last;
  assign pop  = fifo_vld && i_ready;

  // While EMPTY the accumulator holds T_MISS/0, so a non-taken sample
  // naturally yields the miss encoding for the final result.
  always_comb begin
    push_dat        = '0;
    push_dat.hit    = i_hit || (state_q == ST_HOLD);
    push_dat.t      = take ? i_t      : best_t_q;
    push_dat.tri_id = take ? i_tri_id : best_id_q;
    push_dat.ray_id = ray_cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    best_t_d  = best_t_q;
    best_id_d = best_id_q;
    if (i_valid) begin
      if (i_last) begin
        state_d   = ST_EMPTY;
        best_t_d  = T_MISS;
        best_id_d = '0;
      end else if (take) begin
        state_d   = ST_HOLD;
        best_t_d  = i_t;
        best_id_d = i_tri_id;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_EMPTY;
      best_t_q  <= T_MISS;
      best_id_q <= '0;
    end else begin
      state_q   <= state_d;
      best_t_q  <= best_t_d;
      best_id_q <= best_id_d;
    end
  end

  // The ray counter advances on every completed ray, even one that is dropped.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ray_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) ray_cnt_q <= ray_cnt_q + RAY_ID_W'(1);
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  chit_fifo #(
    .W     ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .wr_vld (push),
    .wr_dat (push_dat),
    .full   (fifo_full),
    .rd_vld (fifo_vld),
    .rd_rdy (i_ready),
    .rd_dat (head)
  );

  // Idle outputs show the reset/miss encoding rather than stale FIFO storage.
  assign o_valid    = fifo_vld;
  assign o_hit      = fifo_vld && head.hit;
  assign o_t        = fifo_vld ? signed'(head.t) : T_MISS;
  assign o_tri_id   = fifo_vld ? head.tri_id : '0;
  assign o_ray_id   = fifo_vld ? head.ray_id : '0;
  assign o_overflow = overflow_q;
endmodule

// File: tb/tb_closest_hit_tracker.sv
module tb_closest_hit_tracker;
  localparam int DEPTH = 4;

  logic               i_clk;
  logic               i_rstn;
  logic               i_valid;
  logic signed [31:0] i_t;
  logic               i_hit;
  logic [15:0]        i_tri_id;
  logic               i_last;
  logic               i_ready;
  logic               o_valid;
  logic               o_hit;
  logic signed [31:0] o_t;
  logic [15:0]        o_tri_id;
  logic [15:0]        o_ray_id;
  logic               o_overflow;

  closest_hit_tracker #(
    .TRI_ID_W   (16),
    .RAY_ID_W   (16),
    .FIFO_DEPTH (DEPTH),
    .T_MISS     (32'sh7FFFFFFF)
  ) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_valid    (i_valid),
    .i_t        (i_t),
    .i_hit      (i_hit),
    .i_tri_id   (i_tri_id),
    .i_last     (i_last),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_hit      (o_hit),
    .o_t        (o_t),
    .o_tri_id   (o_tri_id),
    .o_ray_id   (o_ray_id),
    .o_overflow (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic               hit;
    logic signed [31:0] t;
    logic [15:0]        id;
  } smp_t;

  typedef struct {
    logic               hit;
    logic signed [31:0] t;
    logic [15:0]        id;
    logic [15:0]        ray;
  } res_t;

  smp_t ray_smp[$];
  res_t exp_q[$];
  int   mdl_ray;
  bit   mdl_ovf;

  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: nearest hit over the whole list of samples, first index wins ties.
  function automatic res_t reduce_ray();
    res_t r;
    int   best;
    best = -1;
    foreach (ray_smp[i])
      if (ray_smp[i].hit && (best < 0 || ray_smp[i].t < ray_smp[best].t)) best = i;
    r.ray = 16'(mdl_ray);
    if (best < 0) begin
      r.hit = 1'b0; r.t = 32'sh7FFFFFFF; r.id = 16'h0;
    end else begin
      r.hit = 1'b1; r.t = ray_smp[best].t; r.id = ray_smp[best].id;
    end
    return r;
  endfunction

  task automatic mdl_clear();
    ray_smp.delete();
    exp_q.delete();
    mdl_ray = 0;
    mdl_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    chk("o_valid", 64'(o_valid), 64'(exp_q.size() != 0));
    chk("o_overflow", 64'(o_overflow), 64'(mdl_ovf));
    if (exp_q.size() != 0) begin
      chk("o_hit", 64'(o_hit), 64'(exp_q[0].hit));
      chk("o_t", 64'(o_t), 64'(exp_q[0].t));
      chk("o_tri_id", 64'(o_tri_id), 64'(exp_q[0].id));
      chk("o_ray_id", 64'(o_ray_id), 64'(exp_q[0].ray));
    end
  endtask

  // One clock: model updates from the inputs present at the edge, then outputs are compared.
  task automatic step();
    bit   pop;
    bit   do_push;
    res_t r;
    @(posedge i_clk);
    pop     = (exp_q.size() != 0) && i_ready;
    do_push = 1'b0;
    if (i_valid) begin
      ray_smp.push_back('{i_hit, i_t, i_tri_id});
      if (i_last) begin
        r = reduce_ray();
        ray_smp.delete();
        if (exp_q.size() == DEPTH && !pop) mdl_ovf = 1'b1;
        else do_push = 1'b1;
        mdl_ray = (mdl_ray + 1) % 65536;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(r);
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic signed [31:0] t, input bit h,
                       input logic [15:0] id, input bit l);
    i_valid = v; i_t = t; i_hit = h; i_tri_id = id; i_last = l;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 32'sh0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rstn = 1'b0;
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_hit", 64'(o_hit), 64'd0);
    chk("rst_t", 64'(o_t), 64'h7FFFFFFF);
    chk("rst_tri", 64'(o_tri_id), 64'd0);
    chk("rst_ray", 64'(o_ray_id), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    mdl_clear();
    i_valid = 1'b0; i_last = 1'b0; i_hit = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  initial begin
    int cnt;
    n_chk = 0; n_pass = 0;
    i_rstn = 1'b0; i_valid = 1'b0; i_t = '0; i_hit = 1'b0;
    i_tri_id = '0; i_last = 1'b0; i_ready = 1'b1;
    mdl_clear();
    #12;
    i_rstn = 1'b1;

    // 1: reset in the middle of a ray leaves no stale best
    drive(1, 32'sh1000, 1, 16'd77, 0);
    drive(1, 32'sh0800, 1, 16'd78, 0);
    do_reset();
    drive(1, 32'sh5000, 1, 16'd11, 1);
    chk("t1_ray0", 64'(o_ray_id), 64'd0);
    chk("t1_tri", 64'(o_tri_id), 64'd11);
    idle();

    // 2: nearest of three, last sample a miss
    do_reset();
    drive(1, 32'sh30000, 1, 16'd5, 0);
    drive(1, 32'sh18000, 1, 16'd9, 0);
    drive(1, 32'sh10000, 0, 16'd2, 1);
    chk("t2_valid", 64'(o_valid), 64'd1);
    chk("t2_hit", 64'(o_hit), 64'd1);
    chk("t2_t", 64'(o_t), 64'h18000);
    chk("t2_tri", 64'(o_tri_id), 64'd9);
    chk("t2_ray", 64'(o_ray_id), 64'd0);
    idle();

    // 3: tie keeps the earlier triangle
    do_reset();
    drive(1, 32'sh20000, 1, 16'd3, 0);
    drive(1, 32'sh20000, 1, 16'd4, 1);
    chk("t3_tri", 64'(o_tri_id), 64'd3);
    idle();

    // 4: all-miss ray, then single-sample rays every cycle
    do_reset();
    drive(1, 32'sh100, 0, 16'd1, 0);
    drive(1, 32'sh200, 0, 16'd2, 1);
    chk("t4_hit", 64'(o_hit), 64'd0);
    chk("t4_t", 64'(o_t), 64'h7FFFFFFF);
    chk("t4_tri", 64'(o_tri_id), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      drive(1, 32'(k << 16), 1, 16'(k + 40), 1);
      chk("t4_ray_seq", 64'(o_ray_id), 64'(k));
    end
    idle();

    // 5: overflow with consumer stalled, then drain
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) drive(1, 32'(k << 12), 1, 16'(k), 1);
    chk("t5_ovf", 64'(o_overflow), 64'd1);
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_drain_id", 64'(o_ray_id), 64'(k));
      idle();
    end
    chk("t5_empty", 64'(o_valid), 64'd0);
    chk("t5_ovf_sticky", 64'(o_overflow), 64'd1);

    // 6: push and pop on a full FIFO in the same cycle
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) drive(1, 32'sh40, 1, 16'(k), 1);
    i_ready = 1'b1;
    drive(1, 32'sh40, 1, 16'd4, 1);
    chk("t6_no_ovf", 64'(o_overflow), 64'd0);
    cnt = 0;
    for (int k = 0; k < 10 && o_valid; k++) begin
      cnt++;
      idle();
    end
    chk("t6_count", 64'(cnt), 64'd4);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      i_ready = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7,
            ($urandom_range(0, 3) == 0) ? -32'($urandom_range(0, 7) << 16)
                                        : 32'($urandom_range(0, 7) << 16),
            $urandom_range(0, 1) == 1,
            16'($urandom),
            $urandom_range(0, 3) == 0);
    end
    i_ready = 1'b1;
    for (int k = 0; k < 6; k++) idle();

    // 6: ray counter wraps 0xFFFF -> 0x0000
    do_reset();
    i_ready = 1'b1;
    for (int k = 0; k < 65535; k++)
      drive(1, 32'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, 16'(k), 1);
    drive(1, 32'sh10, 1, 16'h1234, 1);
    chk("wrap_ffff", 64'(o_ray_id), 64'hFFFF);
    drive(1, 32'sh10, 1, 16'h1235, 1);
    chk("wrap_0000", 64'(o_ray_id), 64'h0000);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
